// File: rtl/rcs_serial_sub_ctrl.sv
// Nibble-serial wide subtractor: one 4-bit ripple-borrow slice is reused
// for WIDTH/4 cycles, LSB nibble first, with the borrow held in a register
// between cycles. Requester side uses a start/ready/done handshake.

// 4-bit ripple-borrow subtractor: d = a - b - bin, bout = borrow out of bit 3.
module rcs_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  // Ripple the borrow through the four bit positions.
  always_comb begin
    logic br;
    // NOTE: every variable written here gets a value before any branch or
    // loop uses it, so no latch can be inferred.
    d  = '0;
    br = bin;
    for (int i = 0; i < 4; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

module rcs_serial_sub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             brw;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [3:0]       slice_d;
  logic             slice_bout;

  // The single shared slice always works on the low nibble of the shifters.
  rcs_4bit u_slice (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .bin  (brw),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Partial result with the current nibble merged in, so the final commit
  // sees the last nibble in the same cycle it is produced.
  always_comb begin
    res_next              = res;
    res_next[4*idx +: 4]  = slice_d;
  end

  // Handshake outputs decode straight from the state register.
  assign ready = (state == S_IDLE) || (state == S_DONE);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  // Sequencer: accept, step one nibble per cycle, commit on the last one.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    if (rst) begin
      // NOTE: datapath registers are cleared too, so outputs are never X and
      // an aborted operation leaves no stale partial state behind.
      state      <= S_IDLE;
      idx        <= '0;
      brw        <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= borrow_in;
            idx   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          res  <= res_next;
          brw  <= slice_bout;
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          idx  <= idx + IW'(1);
          if (idx == LAST) begin
            diff       <= res_next;
            borrow_out <= slice_bout;
            state      <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rcs_serial_sub_ctrl.sv
// Bench for rcs_serial_sub_ctrl: a WIDTH=16 instance driven with directed
// vectors and a WIDTH=4 instance swept exhaustively. Expected results are
// queued at acceptance; monitors pop and compare on every done pulse.
module tb_rcs_serial_sub_ctrl;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    int          due;
  } exp16_t;

  typedef struct {
    logic [3:0] d;
    logic       bo;
    int         due;
  } exp4_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        bin16 = 1'b0;
  logic        ready16, busy16, done16, bout16;
  logic [15:0] diff16;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       ready4, busy4, done4, bout4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;
  int last4  = -1;

  exp16_t q16[$];
  exp4_t  q4[$];

  rcs_serial_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .borrow_in(bin16), .ready(ready16), .busy(busy16), .done(done16),
    .diff(diff16), .borrow_out(bout16)
  );

  rcs_serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .borrow_in(bin4), .ready(ready4), .busy(busy4), .done(done4),
    .diff(diff4), .borrow_out(bout4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one op on the 16-bit DUT once it is ready. Done is expected in the
  // fifth cycle after the accepting edge, i.e. right after the NIB-th RUN edge.
  task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb,
                         input logic tbin, input logic [15:0] ed,
                         input logic eb, input bit push);
    int n = 0;
    @(negedge clk);
    while (!ready16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready16) check("ready16_timeout", ready16, 1);
    a16 = ta; b16 = tb; bin16 = tbin; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    if (push) q16.push_back('{d: ed, bo: eb, due: cyc + 4});
  endtask

  task automatic do_op4(input logic [3:0] ta, input logic [3:0] tb,
                        input logic [3:0] ed, input logic eb);
    int n = 0;
    @(negedge clk);
    while (!ready4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready4) check("ready4_timeout", ready4, 1);
    a4 = ta; b4 = tb; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    q4.push_back('{d: ed, bo: eb, due: cyc + 1});
  endtask

  // Monitor for the 16-bit DUT.
  always @(negedge clk) begin
    if (!rst && done16) begin
      check("done16_expected", (q16.size() > 0), 1);
      if (q16.size() > 0) begin
        exp16_t e;
        e = q16.pop_front();
        check("diff16", diff16, e.d);
        check("bout16", bout16, e.bo);
        check("latency16", cyc, e.due);
      end
    end
  end

  // Monitor for the 4-bit DUT; back-to-back ops must complete every 2 cycles.
  always @(negedge clk) begin
    if (!rst && done4) begin
      check("done4_expected", (q4.size() > 0), 1);
      if (q4.size() > 0) begin
        exp4_t e;
        e = q4.pop_front();
        check("diff4", diff4, e.d);
        check("bout4", bout4, e.bo);
        check("latency4", cyc, e.due);
      end
      if (last4 >= 0) check("done4_gap", cyc - last4, 2);
      last4 = cyc;
    end
  end

  initial begin
    int n;
    // Reset state while rst is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_diff16", diff16, 0);
    check("rst_bout16", bout16, 0);
    check("rst_ready16", ready16, 1);
    check("rst_busy16", busy16, 0);
    check("rst_done16", done16, 0);
    check("rst_ready4", ready4, 1);
    #1 rst = 1'b0;

    // Basic, ripple/underflow and borrow-in vectors.
    do_op16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b1);
    do_op16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    do_op16(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b1);
    do_op16(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    do_op16(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b1);

    // Start held high for three cycles mid-RUN: ignored.
    repeat (3) @(negedge clk);
    do_op16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; bin16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start16 = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_diff16", diff16, 16'h1000);
    check("hold_idle16", ready16, 1);

    // Back-to-back: second start lands in the DONE cycle.
    do_op16(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1);
    do_op16(16'h0001, 16'h8000, 1'b0, 16'h8001, 1'b1, 1'b1);

    // Reset while idx == 2 aborts the op with no done pulse.
    do_op16(16'hABCD, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_diff16", diff16, 0);
    check("abort_bout16", bout16, 0);
    check("abort_ready16", ready16, 1);
    check("abort_busy16", busy16, 0);
    check("abort_done16", done16, 0);
    repeat (6) @(negedge clk);
    do_op16(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b1);

    // Exhaustive sweep of the 4-bit instance, issued back-to-back.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [3:0] ta, tb, ed;
        ta = 4'(i);
        tb = 4'(j);
        ed = ta - tb;
        do_op4(ta, tb, ed, (i < j));
      end
    end

    n = 0;
    while ((q16.size() != 0 || q4.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain16", q16.size(), 0);
    check("drain4", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
